// File: rtl/memory_mapped_io.sv
// memory_mapped_io: unified 16-bit word-addressed memory shared by CPU (port A) and GPU (port B).
// A true dual-port block RAM holds the data. The three top addresses are decoded as I/O.
//   IO_IN_ADDR   read-only switch register {8'h00, io_in_reg}
//   IO_OUT_ADDR  LED/output register; only the CPU can write it
//   IO_RSVD_ADDR reads 0, writes ignored
// Ports:
//   clock, reset                       clock and synchronous active-high reset
//   cpu_write_data/address/write_enable  CPU store data, word address and write strobe
//   gpu_write_data/address/write_enable  GPU store data, word address and write strobe
//   IOData                             external switch inputs
//   cpu_read_data, gpu_read_data       registered read data, 1-cycle latency
//   io_out                             output register (LEDs)
// Optional feature: define MMIO_INPUT_SYNC_EN to insert a two-flop synchronizer before io_in_reg.
module memory_mapped_io #(
  parameter int unsigned ADDR_WIDTH   = 14,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter logic [15:0] IO_IN_ADDR   = 16'hFFFD,
  parameter logic [15:0] IO_OUT_ADDR  = 16'hFFFE,
  parameter logic [15:0] IO_RSVD_ADDR = 16'hFFFF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] cpu_write_data,
  input  logic [DATA_WIDTH-1:0] gpu_write_data,
  input  logic [15:0]           cpu_address,
  input  logic [15:0]           gpu_address,
  input  logic                  cpu_write_enable,
  input  logic                  gpu_write_enable,
  input  logic [7:0]            IOData,
  output logic [DATA_WIDTH-1:0] cpu_read_data,
  output logic [DATA_WIDTH-1:0] gpu_read_data,
  output logic [DATA_WIDTH-1:0] io_out
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [Depth];

  logic [7:0]            io_in_reg;
  logic [DATA_WIDTH-1:0] io_out_q;

  // Address decode, identical for both ports
  logic cpu_is_in, cpu_is_out, cpu_is_rsvd, cpu_is_ram;
  logic gpu_is_in, gpu_is_out, gpu_is_rsvd, gpu_is_ram;
  logic [ADDR_WIDTH-1:0] cpu_idx, gpu_idx;

  assign cpu_is_in   = (cpu_address == IO_IN_ADDR);
  assign cpu_is_out  = (cpu_address == IO_OUT_ADDR);
  assign cpu_is_rsvd = (cpu_address == IO_RSVD_ADDR);
  assign cpu_is_ram  = ~(cpu_is_in | cpu_is_out | cpu_is_rsvd);
  assign gpu_is_in   = (gpu_address == IO_IN_ADDR);
  assign gpu_is_out  = (gpu_address == IO_OUT_ADDR);
  assign gpu_is_rsvd = (gpu_address == IO_RSVD_ADDR);
  assign gpu_is_ram  = ~(gpu_is_in | gpu_is_out | gpu_is_rsvd);
  assign cpu_idx     = cpu_address[ADDR_WIDTH-1:0];
  assign gpu_idx     = gpu_address[ADDR_WIDTH-1:0];

  logic cpu_ram_we, gpu_ram_we;

  assign cpu_ram_we = cpu_write_enable & cpu_is_ram & ~reset;
  // On a same-index collision the CPU wins, so the GPU write is suppressed entirely
  assign gpu_ram_we = gpu_write_enable & gpu_is_ram & ~reset &
                      ~(cpu_ram_we & (cpu_idx == gpu_idx));

  // Port A: one synchronous read/write process, read-before-write
  logic [DATA_WIDTH-1:0] cpu_ram_q;
  always_ff @(posedge clock) begin
    if (cpu_ram_we) mem[cpu_idx] <= cpu_write_data;
    cpu_ram_q <= mem[cpu_idx];
  end

  // Port B: one synchronous read/write process, read-before-write
  logic [DATA_WIDTH-1:0] gpu_ram_q;
  always_ff @(posedge clock) begin
    if (gpu_ram_we) mem[gpu_idx] <= gpu_write_data;
    gpu_ram_q <= mem[gpu_idx];
  end

  // Input capture
`ifdef MMIO_INPUT_SYNC_EN
  logic [7:0] io_sync_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      io_sync_q <= '0;
      io_in_reg <= '0;
    end else begin
      io_sync_q <= IOData;
      io_in_reg <= io_sync_q;
    end
  end
`else
  always_ff @(posedge clock) begin
    if (reset) io_in_reg <= '0;
    else       io_in_reg <= IOData;
  end
`endif

  // Output register
  always_ff @(posedge clock) begin
    if (reset)                               io_out_q <= '0;
    else if (cpu_write_enable && cpu_is_out) io_out_q <= cpu_write_data;
  end

  assign io_out = io_out_q;

  // I/O read values are registered alongside a RAM select; the final mux sits after the RAM
  // output so the RAM keeps a plain registered read port.
  logic [DATA_WIDTH-1:0] cpu_io_d, gpu_io_d, cpu_io_q, gpu_io_q;
  logic                  cpu_sel_ram_q, gpu_sel_ram_q;

  always_comb begin
    cpu_io_d = '0;
    if (cpu_is_in)       cpu_io_d = {8'h00, io_in_reg};
    else if (cpu_is_out) cpu_io_d = io_out_q;
  end

  always_comb begin
    gpu_io_d = '0;
    if (gpu_is_in)       gpu_io_d = {8'h00, io_in_reg};
    else if (gpu_is_out) gpu_io_d = io_out_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cpu_io_q      <= '0;
      gpu_io_q      <= '0;
      cpu_sel_ram_q <= 1'b0;
      gpu_sel_ram_q <= 1'b0;
    end else begin
      cpu_io_q      <= cpu_io_d;
      gpu_io_q      <= gpu_io_d;
      cpu_sel_ram_q <= cpu_is_ram;
      gpu_sel_ram_q <= gpu_is_ram;
    end
  end

  assign cpu_read_data = cpu_sel_ram_q ? cpu_ram_q : cpu_io_q;
  assign gpu_read_data = gpu_sel_ram_q ? gpu_ram_q : gpu_io_q;

endmodule

// File: tb/tb_memory_mapped_io.sv
module tb_memory_mapped_io;

  localparam int unsigned AW    = 14;
  localparam int          Depth = 1 << AW;
`ifdef MMIO_INPUT_SYNC_EN
  localparam bit Sync = 1'b1;
`else
  localparam bit Sync = 1'b0;
`endif

  logic        clock, reset;
  logic [15:0] cpu_write_data, gpu_write_data, cpu_address, gpu_address;
  logic        cpu_write_enable, gpu_write_enable;
  logic [7:0]  IOData;
  logic [15:0] cpu_read_data, gpu_read_data, io_out;

  memory_mapped_io dut (
    .clock            (clock),
    .reset            (reset),
    .cpu_write_data   (cpu_write_data),
    .gpu_write_data   (gpu_write_data),
    .cpu_address      (cpu_address),
    .gpu_address      (gpu_address),
    .cpu_write_enable (cpu_write_enable),
    .gpu_write_enable (gpu_write_enable),
    .IOData           (IOData),
    .cpu_read_data    (cpu_read_data),
    .gpu_read_data    (gpu_read_data),
    .io_out           (io_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: memory as a sparse map of written words, I/O as plain variables
  logic [15:0] mem_m [int];
  logic [15:0] io_out_m = '0;
  logic [7:0]  io_in_m  = '0;
  logic [7:0]  sync_m   = '0;
  logic [15:0] exp_cpu, exp_gpu;
  bit          cpu_known, gpu_known;

  function automatic bit is_ram(input logic [15:0] a);
    return a < 16'hFFFD;
  endfunction

  task automatic model_read(input logic [15:0] a, output logic [15:0] d, output bit k);
    int i;
    k = 1'b1;
    d = '0;
    i = int'(a) % Depth;
    if (a == 16'hFFFD)      d = {8'h00, io_in_m};
    else if (a == 16'hFFFE) d = io_out_m;
    else if (a == 16'hFFFF) d = '0;
    else if (mem_m.exists(i)) d = mem_m[i];
    else k = 1'b0;
  endtask

  // Drive one cycle, advance the model, then sample 1 time unit after the edge
  task automatic step(input logic r, input logic cwe, input logic [15:0] ca, input logic [15:0] cwd,
                      input logic gwe, input logic [15:0] ga, input logic [15:0] gwd,
                      input logic [7:0] iod);
    reset = r; cpu_write_enable = cwe; cpu_address = ca; cpu_write_data = cwd;
    gpu_write_enable = gwe; gpu_address = ga; gpu_write_data = gwd; IOData = iod;
    if (r) begin
      exp_cpu = '0; exp_gpu = '0; cpu_known = 1'b1; gpu_known = 1'b1;
      io_out_m = '0; io_in_m = '0; sync_m = '0;
    end else begin
      model_read(ca, exp_cpu, cpu_known);
      model_read(ga, exp_gpu, gpu_known);
      if (gwe && is_ram(ga) && !(cwe && is_ram(ca) && (int'(ca) % Depth == int'(ga) % Depth)))
        mem_m[int'(ga) % Depth] = gwd;
      if (cwe && is_ram(ca)) mem_m[int'(ca) % Depth] = cwd;
      if (cwe && ca == 16'hFFFE) io_out_m = cwd;
      if (Sync) begin
        io_in_m = sync_m;
        sync_m  = iod;
      end else begin
        io_in_m = iod;
      end
    end
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic        rst, cwe;
    logic [15:0] ca, cwd;
    logic        gwe;
    logic [15:0] ga, gwd;
    logic [7:0]  iod;
    logic [15:0] e_cpu, e_gpu, e_out;
    logic [2:0]  chk;  // [2] cpu, [1] gpu, [0] io_out
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic cwe, logic [15:0] ca, logic [15:0] cwd, logic gwe,
                              logic [15:0] ga, logic [15:0] gwd, logic [7:0] iod,
                              logic [15:0] e_cpu, logic [15:0] e_gpu, logic [15:0] e_out,
                              logic [2:0] chk);
    vec_t v;
    v.rst = rst; v.cwe = cwe; v.ca = ca; v.cwd = cwd; v.gwe = gwe; v.ga = ga; v.gwd = gwd;
    v.iod = iod; v.e_cpu = e_cpu; v.e_gpu = e_gpu; v.e_out = e_out; v.chk = chk;
    return v;
  endfunction

  function automatic logic [15:0] rand_addr();
    logic [15:0] low;
    low = 16'($urandom_range(0, 15));
    case ($urandom_range(0, 5))
      0, 1, 2: return low;
      3:       return 16'h4000 | low;  // aliases onto the low indices
      4:       return 16'hFFFD + 16'($urandom_range(0, 2));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic [15:0] io_in_lat;
    io_in_lat = Sync ? 16'h0000 : 16'h0045;
    // rst cwe ca cwd gwe ga gwd iod | e_cpu e_gpu e_out chk
    vecs.push_back(mk(1, 0, 16'hFFFD, 0, 0, 16'hFFFF, 0, 8'h45, 0, 0, 0, 3'b111));
    vecs.push_back(mk(1, 1, 16'hFFFE, 16'hFFFF, 1, 16'h0020, 16'hDEAD, 8'h45, 0, 0, 0, 3'b111));
    vecs.push_back(mk(0, 0, 16'hFFFD, 0, 0, 16'hFFFF, 0, 8'h45, 0, 0, 0, 3'b111));
    vecs.push_back(mk(0, 0, 16'hFFFD, 0, 0, 16'hFFFF, 0, 8'h45, io_in_lat, 0, 0, 3'b111));
    vecs.push_back(mk(0, 0, 16'hFFFD, 0, 0, 16'hFFFF, 0, 8'h45, 16'h0045, 0, 0, 3'b111));
    vecs.push_back(mk(0, 1, 16'h0000, 16'hBEEF, 0, 16'hFFFD, 0, 8'h45, 0, 16'h0045, 0, 3'b011));
    vecs.push_back(mk(0, 1, 16'h0001, 16'h1234, 0, 16'hFFFD, 0, 8'h45, 0, 16'h0045, 0, 3'b011));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0001, 0, 8'h45, 16'hBEEF, 16'h1234, 0, 3'b111));
    vecs.push_back(mk(0, 0, 16'h0001, 0, 0, 16'h0000, 0, 8'h45, 16'h1234, 16'hBEEF, 0, 3'b111));
    vecs.push_back(mk(0, 1, 16'hFFFE, 16'h00A5, 0, 16'hFFFE, 0, 8'h45, 0, 0, 16'h00A5, 3'b111));
    vecs.push_back(mk(0, 0, 16'hFFFE, 0, 1, 16'hFFFE, 16'hBBBB, 8'h45,
                      16'h00A5, 16'h00A5, 16'h00A5, 3'b111));
    vecs.push_back(mk(0, 0, 16'hFFFE, 0, 0, 16'hFFFE, 0, 8'h45,
                      16'h00A5, 16'h00A5, 16'h00A5, 3'b111));
    vecs.push_back(mk(0, 1, 16'h0010, 16'h1111, 1, 16'h0010, 16'h2222, 8'h45,
                      0, 0, 16'h00A5, 3'b001));
    vecs.push_back(mk(0, 0, 16'h0010, 0, 0, 16'h0010, 0, 8'h45,
                      16'h1111, 16'h1111, 16'h00A5, 3'b111));
    vecs.push_back(mk(0, 1, 16'h3FFF, 16'hAAAA, 1, 16'h3FFD, 16'hCCCC, 8'h45,
                      0, 0, 16'h00A5, 3'b001));
    vecs.push_back(mk(0, 1, 16'hFFFF, 16'h5555, 1, 16'hFFFD, 16'h5555, 8'h45,
                      0, 16'h0045, 16'h00A5, 3'b111));
    vecs.push_back(mk(0, 1, 16'hFFFD, 16'h5555, 0, 16'hFFFF, 0, 8'h45,
                      16'h0045, 0, 16'h00A5, 3'b111));
    vecs.push_back(mk(0, 0, 16'h3FFF, 0, 0, 16'h3FFD, 0, 8'h45,
                      16'hAAAA, 16'hCCCC, 16'h00A5, 3'b111));
    vecs.push_back(mk(0, 1, 16'h0005, 16'h0001, 0, 16'hFFFF, 0, 8'h45, 0, 0, 16'h00A5, 3'b011));
    vecs.push_back(mk(0, 1, 16'h0005, 16'h0002, 0, 16'h0005, 0, 8'h45,
                      16'h0001, 16'h0001, 16'h00A5, 3'b111));
    vecs.push_back(mk(0, 0, 16'h0005, 0, 0, 16'h0005, 0, 8'h45,
                      16'h0002, 16'h0002, 16'h00A5, 3'b111));
    vecs.push_back(mk(0, 0, 16'hFFFF, 0, 1, 16'h0030, 16'h3030, 8'h45, 0, 0, 16'h00A5, 3'b101));
    vecs.push_back(mk(0, 0, 16'h0030, 0, 0, 16'hFFFD, 0, 8'h9A,
                      16'h3030, 16'h0045, 16'h00A5, 3'b111));
    vecs.push_back(mk(0, 0, 16'hFFFD, 0, 0, 16'hFFFD, 0, 8'h9A,
                      Sync ? 16'h0045 : 16'h009A, Sync ? 16'h0045 : 16'h009A, 16'h00A5, 3'b111));
    vecs.push_back(mk(0, 0, 16'hFFFD, 0, 0, 16'hFFFD, 0, 8'h9A,
                      16'h009A, 16'h009A, 16'h00A5, 3'b111));

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].cwe, vecs[i].ca, vecs[i].cwd, vecs[i].gwe, vecs[i].ga,
           vecs[i].gwd, vecs[i].iod);
      if (vecs[i].chk[2]) check($sformatf("vec%0d cpu_read_data", i), cpu_read_data, vecs[i].e_cpu);
      if (vecs[i].chk[1]) check($sformatf("vec%0d gpu_read_data", i), gpu_read_data, vecs[i].e_gpu);
      if (vecs[i].chk[0]) check($sformatf("vec%0d io_out", i), io_out, vecs[i].e_out);
    end

    // Reset must not clear RAM, and RAM writes during reset are dropped
    step(0, 1, 16'h0020, 16'h7777, 0, 16'hFFFF, 0, 8'h9A);
    step(1, 1, 16'h0020, 16'hDEAD, 1, 16'h0021, 16'hDEAD, 8'h9A);
    check("rst cpu_read_data", cpu_read_data, 16'h0000);
    check("rst gpu_read_data", gpu_read_data, 16'h0000);
    check("rst io_out", io_out, 16'h0000);
    step(0, 1, 16'h0021, 16'h4242, 0, 16'h0020, 0, 8'h9A);
    check("ram kept over reset", gpu_read_data, 16'h7777);
    step(0, 0, 16'h0021, 0, 0, 16'h0020, 0, 8'h9A);
    check("post-reset write", cpu_read_data, 16'h4242);
    check("reset write dropped", gpu_read_data, 16'h7777);

    // Randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      logic        r, cwe, gwe;
      logic [15:0] ca, ga;
      r   = ($urandom_range(0, 63) == 0);
      cwe = $urandom_range(0, 1) == 1;
      gwe = $urandom_range(0, 1) == 1;
      ca  = rand_addr();
      ga  = ($urandom_range(0, 3) == 0) ? ca : rand_addr();
      step(r, cwe, ca, 16'($urandom), gwe, ga, 16'($urandom), 8'($urandom));
      if (cpu_known) check("rand cpu_read_data", cpu_read_data, exp_cpu);
      if (gpu_known) check("rand gpu_read_data", gpu_read_data, exp_gpu);
      check("rand io_out", io_out, io_out_m);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
